line_buffer_sched: RTL and testbench
====================================

# line_buffer_sched

Schedules the three rotating line RAMs that feed the Sobel 3x3 window. Sits between the camera capture stage (VSYNC/Href/pixel strobe) and the line RAM bank plus Sobel datapath. It generates one-hot write enables, write and read addresses, and top/middle bank selects. It also issues a window-valid strobe once three rows and three columns are available. It holds no pixel data; the datapath delays pixel data by one cycle to align with `wr_en`.

## Interface
- `WIDTH_SOBEL`, 8: active pixels per row stored; columns ≥ `WIDTH_SOBEL` are dropped.
- `AW`, 9: address width of each line RAM; `WIDTH_SOBEL` ≤ 2^AW.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `VSYNC`  in  1  frame sync; a rising edge starts a new frame.
- `Href`  in  1  row active; a rising edge starts a row, a falling edge ends it.
- `pix_valid`  in  1  pixel strobe; honoured only while `Href`=1.
- `wr_en`  out  3  one-hot write enable to line RAM bank 0/1/2.
- `wr_addr`  out  AW  write column.
- `rd_en`  out  1  read strobe to all three banks.
- `rd_addr`  out  AW  read column; always equals `wr_addr` when `rd_en`=1.
- `bank_top`  out  2  bank holding the row two rows back.
- `bank_mid`  out  2  bank holding the previous row.
- `win_valid`  out  1  3x3 window complete at the Sobel input.
- `row_done`  out  1  one-cycle pulse at the end of each non-empty row.
- `ovf`  out  1  sticky flag: a pixel arrived with column ≥ `WIDTH_SOBEL`.

## Operation
- **Edge detect:** `VSYNC_q` and `Href_q` are registered copies. An edge is `X && !X_q`; a fall is `!X && X_q`. `VSYNC_q` resets to 1, so a VSYNC already high at reset release is not an edge.
- **States:**
  - IDLE: after reset. Leaves only on a VSYNC rise.
  - ROW_WAIT: waits for an Href rise.
  - ROW_ACT: accepts pixels. Returns to ROW_WAIT on an Href fall.
- **VSYNC rise:** from any state, go to ROW_WAIT and clear `rows_stored`, `wr_bank`, `col` and `ovf` to 0.
  - VSYNC rise has priority over a simultaneous Href rise; that row is ignored.
- **Href rise:** clear `col` to 0 and enter ROW_ACT.
  - A `pix_valid` in the same cycle is accepted as column 0.
- **Pixel accept (`pix_valid`, ROW_ACT or row-start cycle, `col` < `WIDTH_SOBEL`):**
  - Registered outputs: `wr_en` = 1<<`wr_bank`, `wr_addr` = `col`.
  - If `rows_stored` = 2, also `rd_en` = 1 and `rd_addr` = `col`.
  - `col` increments by 1.
- **Pixel with `col` ≥ `WIDTH_SOBEL`:** no enables; set `ovf` = 1; `col` saturates.
- **`win_valid`:** registered copy of (`rd_en` && `rd_addr` ≥ 2).
- **Href fall with `col` > 0:**
  - `wr_bank` advances 0→1→2→0.
  - `rows_stored` increments, saturating at 2.
  - `row_done` pulses for one cycle.
- **Href fall with `col` = 0:** no rotation, no pulse.
- **Bank selects (combinational from `wr_bank`):**
  - `bank_top` = (`wr_bank`+1) mod 3.
  - `bank_mid` = (`wr_bank`+2) mod 3.
- **Ignored inputs:** `pix_valid` with `Href`=0, and any input activity in IDLE.

## Timing
- **Reset values:**
  - `wr_en`=000, `wr_addr`=0, `rd_en`=0, `rd_addr`=0, `win_valid`=0, `row_done`=0, `ovf`=0.
  - `wr_bank`=0, so `bank_top`=1 and `bank_mid`=2.
  - State IDLE.
- **Async reset mid-row:** outputs go to reset values immediately, without waiting for a clock edge. The partial frame is discarded and the next VSYNC rise is required.
- **Latency:**
  - `pix_valid` sampled at edge k → `wr_en`/`rd_en`/addresses valid from edge k to edge k+1.
  - `win_valid` is valid from edge k+1 to edge k+2, matching the 1-cycle RAM read latency.
  - `row_done` is high the cycle after the Href fall is sampled.
  - `bank_top`/`bank_mid` change in that same cycle.
- **Throughput:** one pixel per clock. Gapped `pix_valid` is allowed; enables are deasserted in gap cycles.
- **VSYNC rise mid-row:** enables from a pixel sampled in that same cycle are suppressed; `ovf` clears at the next edge.

## Test plan
- **Reset:** hold `rst`=0, toggle inputs → all outputs at reset values, `bank_top`=1, `bank_mid`=2. Release with VSYNC=1 → stays IDLE until VSYNC falls and rises again.
- **Three rows of 8 back-to-back pixels after a VSYNC rise (`WIDTH_SOBEL`=8):**
  - Row 0: `wr_en`=001, addresses 0..7, no `rd_en`.
  - Row 1: `wr_en`=010, no `rd_en`.
  - Row 2: `wr_en`=100, `rd_en` ×8 with `rd_addr` 0..7, `bank_top`=0, `bank_mid`=1, `win_valid` ×6 (columns 2..7).
  - `row_done` ×3.
- **Row of 10 pixels:** columns 8 and 9 produce no enables and set `ovf`=1. `ovf` holds across rows and clears after the next VSYNC rise.
- **VSYNC rise during row 3 of a frame:** enables drop next cycle. The next row writes bank 0 (`wr_en`=001) with no `rd_en`; `bank_top`=1.
- **Row-start and gaps:** `pix_valid` in the same cycle as the Href rise → `wr_addr`=0 accepted. With `pix_valid` every other cycle, enables pulse on alternate cycles and addresses stay contiguous.
- **Empty row:** Href high for 5 cycles with no `pix_valid` → no `row_done`, `wr_bank` unchanged.

Source files
------------

// File: rtl/line_buffer_sched_if.sv
// Handshake bundle between the capture stage, the line RAM bank and the scheduler.
// The scheduler uses the slave view; the capture/bench side uses the master view.
interface line_buffer_sched_if #(
    parameter int AW = 9
);
    logic          VSYNC;
    logic          Href;
    logic          pix_valid;
    logic [2:0]    wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [1:0]    bank_top;
    logic [1:0]    bank_mid;
    logic          win_valid;
    logic          row_done;
    logic          ovf;

    modport master (
        output VSYNC, Href, pix_valid,
        input  wr_en, wr_addr, rd_en, rd_addr, bank_top, bank_mid,
               win_valid, row_done, ovf
    );

    modport slave (
        input  VSYNC, Href, pix_valid,
        output wr_en, wr_addr, rd_en, rd_addr, bank_top, bank_mid,
               win_valid, row_done, ovf
    );
endinterface

// File: rtl/line_buffer_sched.sv
// Rotating three-line RAM scheduler for the Sobel 3x3 window: write/read enables,
// addresses, top/middle bank selects and window-valid, driven from VSYNC/Href/pixel strobes.
module line_buffer_sched #(
    parameter int WIDTH_SOBEL = 8,
    parameter int AW          = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    line_buffer_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_WAIT = 2'd1,
        ROW_ACT  = 2'd2
    } state_t;

    localparam logic [AW:0]   COL_MAX = (AW+1)'(WIDTH_SOBEL);
    localparam logic [AW:0]   COL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] WIN_COL = AW'(2);

    // Bank index arithmetic modulo 3 on the 2-bit bank encoding.
    function automatic logic [1:0] mod3_add(input logic [1:0] b, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, b} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end else begin
            s = s;
        end
        return s[1:0];
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;
    logic          vsync_q_r;
    logic          href_q_r;
    logic          vs_rise_s;
    logic          h_rise_s;
    logic          h_fall_s;
    logic          row_start_s;
    logic          close_row_s;
    logic          accept_s;
    logic          in_range_s;
    logic [AW:0]   col_r;
    logic [AW:0]   col_eff_s;
    logic [1:0]    wr_bank_r;
    logic [1:0]    rows_stored_r;
    logic [2:0]    wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic          rd_en_r;
    logic [AW-1:0] rd_addr_r;
    logic          win_valid_r;
    logic          row_done_r;
    logic          ovf_r;

    // Edge detection, next-state selection and the per-cycle pixel decision.
    always_comb begin
        vs_rise_s   = bus.VSYNC & ~vsync_q_r;
        h_rise_s    = bus.Href & ~href_q_r;
        h_fall_s    = ~bus.Href & href_q_r;
        row_start_s = 1'b0;
        close_row_s = 1'b0;
        state_nxt_s = state_r;
        if (vs_rise_s) begin
            state_nxt_s = ROW_WAIT;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt_s = IDLE;
                end
                ROW_WAIT: begin
                    if (h_rise_s) begin
                        state_nxt_s = ROW_ACT;
                        row_start_s = 1'b1;
                    end else begin
                        state_nxt_s = ROW_WAIT;
                    end
                end
                ROW_ACT: begin
                    if (h_fall_s) begin
                        state_nxt_s = ROW_WAIT;
                        close_row_s = 1'b1;
                    end else begin
                        state_nxt_s = ROW_ACT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
        // A pixel on the row-start cycle is column 0 regardless of the stale counter.
        col_eff_s  = row_start_s ? {(AW+1){1'b0}} : col_r;
        accept_s   = bus.pix_valid & bus.Href &
                     (row_start_s | ((state_r == ROW_ACT) & ~vs_rise_s));
        in_range_s = (col_eff_s < COL_MAX);
    end

    // State and input history registers; VSYNC history resets high so a level is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            vsync_q_r <= 1'b1;
            href_q_r  <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vsync_q_r <= bus.VSYNC;
            href_q_r  <= bus.Href;
        end
    end

    // Column/bank bookkeeping and registered RAM control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_r         <= {(AW+1){1'b0}};
            wr_bank_r     <= 2'd0;
            rows_stored_r <= 2'd0;
            wr_en_r       <= 3'b000;
            wr_addr_r     <= {AW{1'b0}};
            rd_en_r       <= 1'b0;
            rd_addr_r     <= {AW{1'b0}};
            win_valid_r   <= 1'b0;
            row_done_r    <= 1'b0;
            ovf_r         <= 1'b0;
        end else begin
            wr_en_r     <= 3'b000;
            rd_en_r     <= 1'b0;
            row_done_r  <= 1'b0;
            win_valid_r <= rd_en_r & (rd_addr_r >= WIN_COL);
            if (vs_rise_s) begin
                col_r         <= {(AW+1){1'b0}};
                wr_bank_r     <= 2'd0;
                rows_stored_r <= 2'd0;
                ovf_r         <= 1'b0;
            end else if (accept_s) begin
                if (in_range_s) begin
                    wr_en_r   <= 3'b001 << wr_bank_r;
                    wr_addr_r <= col_eff_s[AW-1:0];
                    if (rows_stored_r == 2'd2) begin
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= col_eff_s[AW-1:0];
                    end else begin
                        rd_en_r   <= 1'b0;
                    end
                    col_r <= col_eff_s + COL_ONE;
                end else begin
                    ovf_r <= 1'b1;
                    col_r <= col_eff_s;
                end
            end else if (row_start_s) begin
                col_r <= {(AW+1){1'b0}};
            end else if (close_row_s && (col_r != {(AW+1){1'b0}})) begin
                wr_bank_r     <= mod3_add(wr_bank_r, 2'd1);
                rows_stored_r <= (rows_stored_r == 2'd2) ? 2'd2 : (rows_stored_r + 2'd1);
                row_done_r    <= 1'b1;
            end else begin
                col_r <= col_r;
            end
        end
    end

    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.win_valid = win_valid_r;
    assign bus.row_done  = row_done_r;
    assign bus.ovf       = ovf_r;
    assign bus.bank_top  = mod3_add(wr_bank_r, 2'd1);
    assign bus.bank_mid  = mod3_add(wr_bank_r, 2'd2);

endmodule

// File: tb/tb_line_buffer_sched.sv
// Self-checking bench for line_buffer_sched: frame/row reference model plus directed and random stimulus.
module tb_line_buffer_sched;
    localparam int W  = 8;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    line_buffer_sched_if #(.AW(AW)) bus ();
    line_buffer_sched #(.WIDTH_SOBEL(W), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    int cnt_wr = 0, cnt_rd = 0, cnt_win = 0, cnt_done = 0;

    // Reference model state: frame/row flags, column, number of completed rows in frame.
    bit       m_frame = 1'b0, m_row = 1'b0, m_ovf = 1'b0;
    int       m_col = 0, m_rows = 0;
    bit       vs_prev = 1'b1, h_prev = 1'b0;
    logic [2:0] e_wr_en = 3'b000;
    int       e_wr_addr = 0, e_rd_addr = 0;
    bit       e_rd_en = 1'b0, e_win = 1'b0, e_row_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        bit vr, hr, hf;
        if (!rst) begin
            m_frame = 1'b0; m_row = 1'b0; m_ovf = 1'b0; m_col = 0; m_rows = 0;
            vs_prev = 1'b1; h_prev = 1'b0;
            e_wr_en = 3'b000; e_wr_addr = 0; e_rd_addr = 0;
            e_rd_en = 1'b0; e_win = 1'b0; e_row_done = 1'b0;
        end else begin
            vr = bus.VSYNC && !vs_prev;
            hr = bus.Href && !h_prev;
            hf = !bus.Href && h_prev;
            e_win = e_rd_en && (e_rd_addr >= 2);
            e_wr_en = 3'b000; e_rd_en = 1'b0; e_row_done = 1'b0;
            if (vr) begin
                m_frame = 1'b1; m_row = 1'b0; m_col = 0; m_rows = 0; m_ovf = 1'b0;
            end else if (m_frame) begin
                if (!m_row && hr) begin
                    m_row = 1'b1; m_col = 0;
                end
                if (m_row && bus.Href && bus.pix_valid) begin
                    if (m_col < W) begin
                        e_wr_en   = 3'(1 << (m_rows % 3));
                        e_wr_addr = m_col;
                        if (m_rows >= 2) begin
                            e_rd_en   = 1'b1;
                            e_rd_addr = m_col;
                        end
                        m_col++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end else if (m_row && hf) begin
                    m_row = 1'b0;
                    if (m_col > 0) begin
                        m_rows++;
                        e_row_done = 1'b1;
                    end
                end
            end
            vs_prev = bus.VSYNC;
            h_prev  = bus.Href;
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
        chk("rd_en", 32'(bus.rd_en), 32'(e_rd_en));
        chk("win_valid", 32'(bus.win_valid), 32'(e_win));
        chk("row_done", 32'(bus.row_done), 32'(e_row_done));
        chk("ovf", 32'(bus.ovf), 32'(m_ovf));
        chk("bank_top", 32'(bus.bank_top), 32'((m_rows + 1) % 3));
        chk("bank_mid", 32'(bus.bank_mid), 32'((m_rows + 2) % 3));
        if (e_wr_en != 3'b000 || !rst) chk("wr_addr", 32'(bus.wr_addr), 32'(e_wr_addr));
        if (e_rd_en || !rst) chk("rd_addr", 32'(bus.rd_addr), 32'(e_rd_addr));
        cnt_wr   += (bus.wr_en != 3'b000) ? 1 : 0;
        cnt_rd   += bus.rd_en ? 1 : 0;
        cnt_win  += bus.win_valid ? 1 : 0;
        cnt_done += bus.row_done ? 1 : 0;
    end

    task automatic clr();
        cnt_wr = 0; cnt_rd = 0; cnt_win = 0; cnt_done = 0;
    endtask

    task automatic cyc(input logic v, input logic h, input logic p);
        bus.VSYNC = v; bus.Href = h; bus.pix_valid = p;
        @(negedge clk);
    endtask

    task automatic vsync_pulse();
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic row(input int n, input int gap, input bit start_pix);
        int sent = 0;
        if (!start_pix) cyc(1'b0, 1'b1, 1'b0);
        while (sent < n) begin
            cyc(1'b0, 1'b1, 1'b1);
            sent++;
            repeat (gap) cyc(1'b0, 1'b1, 1'b0);
        end
        if (n == 0) repeat (5) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic h;
        bus.VSYNC = 1'b0; bus.Href = 1'b0; bus.pix_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        // Reset held with input activity, releasing with VSYNC already high.
        for (int i = 0; i < 5; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        #1;
        chk("reset wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset bank_top", 32'(bus.bank_top), 32'd1);
        chk("reset bank_mid", 32'(bus.bank_mid), 32'd2);
        rst = 1'b1;
        clr();
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b0, 1'b0);
        #1;
        chk("idle no writes", 32'(cnt_wr), 32'd0);

        // Three full rows.
        vsync_pulse();
        clr();
        row(8, 0, 1'b0);
        row(8, 0, 1'b0);
        #1;
        chk("row2 bank_top", 32'(bus.bank_top), 32'd0);
        chk("row2 bank_mid", 32'(bus.bank_mid), 32'd1);
        row(8, 0, 1'b0);
        #1;
        chk("frame wr count", 32'(cnt_wr), 32'd24);
        chk("frame rd count", 32'(cnt_rd), 32'd8);
        chk("frame win count", 32'(cnt_win), 32'd6);
        chk("frame row_done", 32'(cnt_done), 32'd3);
        chk("last rd_addr", 32'(bus.rd_addr), 32'd7);

        // Overlong row sets a sticky overflow.
        clr();
        row(10, 0, 1'b0);
        #1;
        chk("ovf set", 32'(bus.ovf), 32'd1);
        chk("ovf row writes", 32'(cnt_wr), 32'd8);
        row(3, 0, 1'b0);
        #1;
        chk("ovf sticky", 32'(bus.ovf), 32'd1);
        vsync_pulse();
        #1;
        chk("ovf cleared", 32'(bus.ovf), 32'd0);

        // VSYNC rise in the middle of the fourth row.
        row(4, 0, 1'b0); row(4, 0, 1'b0); row(4, 0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        #1;
        clr();
        cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("vsync suppress", 32'(cnt_wr), 32'd0);
        chk("vsync bank_top", 32'(bus.bank_top), 32'd1);
        clr();
        row(4, 0, 1'b0);
        #1;
        chk("post-vsync writes", 32'(cnt_wr), 32'd4);
        chk("post-vsync no rd", 32'(cnt_rd), 32'd0);

        // Empty row, then a gapped row with a pixel on the row-start cycle.
        vsync_pulse();
        clr();
        row(0, 0, 1'b0);
        #1;
        chk("empty row_done", 32'(cnt_done), 32'd0);
        chk("empty bank_top", 32'(bus.bank_top), 32'd1);
        clr();
        row(4, 1, 1'b1);
        #1;
        chk("gapped writes", 32'(cnt_wr), 32'd4);
        chk("gapped row_done", 32'(cnt_done), 32'd1);

        // Asynchronous reset in the middle of a row.
        cyc(1'b0, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("async rst wr_en", 32'(bus.wr_en), 32'd0);
        chk("async rst bank_top", 32'(bus.bank_top), 32'd1);
        clr();
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b0, 1'b0);
        #1;
        chk("after rst idle", 32'(cnt_wr), 32'd0);

        // Random traffic against the model.
        vsync_pulse();
        h = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, (i < 2000) ? 7 : 13) == 0) h = ~h;
            cyc(1'($urandom_range(0, 59) == 0), h, 1'($urandom_range(0, 9) < 7));
        end
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
